// File: rtl/valu_ctrl.sv
// Issue/writeback controller for the fixed-latency vector ALU sharing the FLU writeback port.
// Optional build macro VALU_CTRL_B2B_EN lets a new op be accepted in the writeback cycle.
module valu_ctrl #(
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned LATENCY       = 2,
    parameter int unsigned STARVE_MAX    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valu_valid_i,
    output logic                     valu_ready_o,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [31:0]              operand_a_i,
    input  logic [31:0]              operand_b_i,
    output logic [31:0]              valu_op_a_o,
    output logic [31:0]              valu_op_b_o,
    input  logic [31:0]              valu_result_i,
    input  logic                     wb_busy_i,
    output logic                     wb_valid_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [31:0]              wb_result_o,
    output logic                     busy_o,
    output logic                     starve_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic [3:0] LAT_M1     = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_THR = 4'(STARVE_MAX);

    state_e                   state_r;
    logic [3:0]               cnt_r;
    logic [3:0]               wait_r;
    logic [31:0]              op_a_r;
    logic [31:0]              op_b_r;
    logic [31:0]              result_r;
    logic [TRANS_ID_BITS-1:0] id_r;
    logic                     accept_s;

    // Handshake decode: ready and writeback strobe follow state plus this cycle's port arbitration
    always_comb begin
        valu_ready_o = 1'b0;
        wb_valid_o   = 1'b0;
        case (state_r)
            IDLE: begin
                valu_ready_o = 1'b1;
                wb_valid_o   = 1'b0;
            end
            EXEC: begin
                valu_ready_o = 1'b0;
                wb_valid_o   = 1'b0;
            end
            WB: begin
                wb_valid_o = ~wb_busy_i & ~flush_i;
`ifdef VALU_CTRL_B2B_EN
                valu_ready_o = ~wb_busy_i & ~flush_i;
`else
                valu_ready_o = 1'b0;
`endif
            end
            default: begin
                valu_ready_o = 1'b0;
                wb_valid_o   = 1'b0;
            end
        endcase
    end

    assign accept_s = valu_ready_o & valu_valid_i & ~flush_i;

    // Output gating: operands and writeback data read as zero outside their owning state
    always_comb begin
        valu_op_a_o   = (state_r == EXEC) ? op_a_r : 32'd0;
        valu_op_b_o   = (state_r == EXEC) ? op_b_r : 32'd0;
        wb_trans_id_o = (state_r == WB) ? id_r : {TRANS_ID_BITS{1'b0}};
        wb_result_o   = (state_r == WB) ? result_r : 32'd0;
        busy_o        = (state_r != IDLE);
        starve_o      = (state_r == WB) && (wait_r >= STARVE_THR);
    end

    // Controller FSM with operand/ID/result capture and writeback wait counting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            wait_r   <= 4'd0;
            op_a_r   <= 32'd0;
            op_b_r   <= 32'd0;
            result_r <= 32'd0;
            id_r     <= {TRANS_ID_BITS{1'b0}};
        end else if (flush_i) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            wait_r  <= 4'd0;
        end else begin
            if (accept_s) begin
                op_a_r <= operand_a_i;
                op_b_r <= operand_b_i;
                id_r   <= trans_id_i;
                cnt_r  <= LAT_M1;
            end
            case (state_r)
                IDLE: begin
                    state_r <= accept_s ? EXEC : IDLE;
                    wait_r  <= 4'd0;
                end
                EXEC: begin
                    if (cnt_r == 4'd0) begin
                        result_r <= valu_result_i;
                        state_r  <= WB;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                    wait_r <= 4'd0;
                end
                WB: begin
                    if (wb_valid_o) begin
                        wait_r  <= 4'd0;
                        state_r <= accept_s ? EXEC : IDLE;
                    end else if (wait_r != 4'd15) begin
                        // Port is held by another unit; count starvation, saturating
                        wait_r <= wait_r + 4'd1;
                    end else begin
                        wait_r <= wait_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wait_r  <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_valu_ctrl.sv
// Directed bench for valu_ctrl: cycle-vector table plus throughput and mid-op reset sequences.
module tb_valu_ctrl;

    logic        clk_s;
    logic        rst_n_s;
    logic        flush_s;
    logic        valid_s;
    logic        ready_s;
    logic [2:0]  id_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] opa_s;
    logic [31:0] opb_s;
    logic [31:0] res_s;
    logic        busy_in_s;
    logic        wbv_s;
    logic [2:0]  wb_id_s;
    logic [31:0] wb_res_s;
    logic        busy_s;
    logic        starve_s;

    int n_chk;
    int n_fail;
    bit b2b;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        bit          rb;
        bit          v;
        bit          f;
        bit          bz;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  id;
        logic [31:0] res;
        bit          er;
        bit          ew;
        logic [2:0]  eid;
        logic [31:0] eres;
        bit          eb;
        bit          es;
        logic [31:0] eoa;
        logic [31:0] eob;
    } vec_t;

    vec_t vec_q[$];

    valu_ctrl #(.TRANS_ID_BITS(3), .LATENCY(2), .STARVE_MAX(4)) dut (
        .clk_i        (clk_s),
        .rst_ni       (rst_n_s),
        .flush_i      (flush_s),
        .valu_valid_i (valid_s),
        .valu_ready_o (ready_s),
        .trans_id_i   (id_s),
        .operand_a_i  (a_s),
        .operand_b_i  (b_s),
        .valu_op_a_o  (opa_s),
        .valu_op_b_o  (opb_s),
        .valu_result_i(res_s),
        .wb_busy_i    (busy_in_s),
        .wb_valid_o   (wbv_s),
        .wb_trans_id_o(wb_id_s),
        .wb_result_o  (wb_res_s),
        .busy_o       (busy_s),
        .starve_o     (starve_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input bit rb, input bit v, input bit f, input bit bz,
                       input logic [31:0] a, input logic [31:0] b, input logic [2:0] id,
                       input logic [31:0] res, input bit er, input bit ew, input logic [2:0] eid,
                       input logic [31:0] eres, input bit eb, input bit es,
                       input logic [31:0] eoa, input logic [31:0] eob);
        vec_t r;
        r.rb = rb; r.v = v; r.f = f; r.bz = bz; r.a = a; r.b = b; r.id = id; r.res = res;
        r.er = er; r.ew = ew; r.eid = eid; r.eres = eres; r.eb = eb; r.es = es;
        r.eoa = eoa; r.eob = eob;
        vec_q.push_back(r);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, ready_s}, 32'd1);
        chk({tag, "_wbv"}, {31'd0, wbv_s}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_s}, 32'd0);
        chk({tag, "_starve"}, {31'd0, starve_s}, 32'd0);
        chk({tag, "_opa"}, opa_s, 32'd0);
        chk({tag, "_wbres"}, wb_res_s, 32'd0);
        chk({tag, "_wbid"}, {29'd0, wb_id_s}, 32'd0);
    endtask

    task automatic idle_inputs();
        valid_s = 1'b0; flush_s = 1'b0; busy_in_s = 1'b0;
        a_s = 32'd0; b_s = 32'd0; id_s = 3'd0; res_s = JUNK;
    endtask

    task automatic do_reset();
        @(negedge clk_s);
        idle_inputs();
        rst_n_s = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk_s);
        rst_n_s = 1'b1;
    endtask

    initial begin
        int acc_q[$];
        int wb_q[$];
        int exp_acc[3];
        int exp_wb[3];
        int got;
        n_chk = 0;
        n_fail = 0;
`ifdef VALU_CTRL_B2B_EN
        b2b = 1'b1;
`else
        b2b = 1'b0;
`endif
        idle_inputs();
        rst_n_s = 1'b0;
        #12;
        check_reset_vals("por");
        rst_n_s = 1'b1;

        // Basic op, no contention: writeback in cycle 3, idle in cycle 4
        add(1,1,0,0, 32'h11,32'h22,3'd3,JUNK,  1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    0,0,3'd0,32'd0,  1,0,32'h11,32'h22);
        add(0,0,0,0, 32'd0,32'd0,3'd0,32'h33,  0,0,3'd0,32'd0,  1,0,32'h11,32'h22);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    b2b,1,3'd3,32'h33, 1,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        // Port busy in cycles 3..8: starve from cycle 7, writeback in cycle 9
        add(1,1,0,0, 32'h11,32'h22,3'd3,JUNK,  1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    0,0,3'd0,32'd0,  1,0,32'h11,32'h22);
        add(0,0,0,0, 32'd0,32'd0,3'd0,32'h33,  0,0,3'd0,32'd0,  1,0,32'h11,32'h22);
        for (int c = 3; c <= 8; c++)
            add(0,0,0,1, 32'd0,32'd0,3'd0,JUNK, 0,0,3'd3,32'h33, 1,(c >= 7),32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    b2b,1,3'd3,32'h33, 1,1,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        // Flush during EXEC
        add(1,1,0,0, 32'h5,32'h6,3'd1,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    0,0,3'd0,32'd0,  1,0,32'h5,32'h6);
        add(0,0,1,0, 32'd0,32'd0,3'd0,32'h77,  0,0,3'd0,32'd0,  1,0,32'h5,32'h6);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        // Flush in the WB cycle suppresses the writeback
        add(1,1,0,0, 32'h11,32'h22,3'd3,JUNK,  1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    0,0,3'd0,32'd0,  1,0,32'h11,32'h22);
        add(0,0,0,0, 32'd0,32'd0,3'd0,32'h33,  0,0,3'd0,32'd0,  1,0,32'h11,32'h22);
        add(0,0,1,0, 32'd0,32'd0,3'd0,JUNK,    0,0,3'd3,32'h33, 1,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        // Valid held high while busy: second request ignored until eligible
        add(1,1,0,0, 32'h7,32'h8,3'd2,JUNK,    1,0,3'd0,32'd0,  0,0,32'd0,32'd0);
        add(0,1,0,0, 32'h99,32'h99,3'd5,JUNK,  0,0,3'd0,32'd0,  1,0,32'h7,32'h8);
        add(0,1,0,0, 32'h99,32'h99,3'd5,32'h0F, 0,0,3'd0,32'd0, 1,0,32'h7,32'h8);
        add(0,1,0,0, 32'h99,32'h99,3'd5,JUNK,  b2b,1,3'd2,32'h0F, 1,0,32'd0,32'd0);
        add(0,0,0,0, 32'd0,32'd0,3'd0,JUNK,    !b2b,0,3'd0,32'd0, b2b,0,
            b2b ? 32'h99 : 32'd0, b2b ? 32'h99 : 32'd0);

        for (int i = 0; i < vec_q.size(); i++) begin
            string t;
            if (vec_q[i].rb) do_reset();
            @(negedge clk_s);
            valid_s = vec_q[i].v; flush_s = vec_q[i].f; busy_in_s = vec_q[i].bz;
            a_s = vec_q[i].a; b_s = vec_q[i].b; id_s = vec_q[i].id; res_s = vec_q[i].res;
            #1;
            t = $sformatf("v%0d", i);
            chk({t, "_ready"}, {31'd0, ready_s}, {31'd0, vec_q[i].er});
            chk({t, "_wbv"}, {31'd0, wbv_s}, {31'd0, vec_q[i].ew});
            chk({t, "_wbid"}, {29'd0, wb_id_s}, {29'd0, vec_q[i].eid});
            chk({t, "_wbres"}, wb_res_s, vec_q[i].eres);
            chk({t, "_busy"}, {31'd0, busy_s}, {31'd0, vec_q[i].eb});
            chk({t, "_starve"}, {31'd0, starve_s}, {31'd0, vec_q[i].es});
            chk({t, "_opa"}, opa_s, vec_q[i].eoa);
            chk({t, "_opb"}, opb_s, vec_q[i].eob);
        end

        // Throughput with continuous valid and a free writeback port
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_s);
            valid_s = 1'b1; busy_in_s = 1'b0; flush_s = 1'b0;
            a_s = c; b_s = c; id_s = 3'(c); res_s = c;
            #1;
            if (ready_s && valid_s) acc_q.push_back(c);
            if (wbv_s) wb_q.push_back(c);
        end
        idle_inputs();
        if (b2b) begin
            exp_acc = '{0, 3, 6}; exp_wb = '{3, 6, 9};
        end else begin
            exp_acc = '{0, 4, 8}; exp_wb = '{3, 7, 11};
        end
        for (int k = 0; k < 3; k++) begin
            got = (k < acc_q.size()) ? acc_q[k] : -1;
            chk($sformatf("tput_acc%0d", k), got, exp_acc[k]);
            got = (k < wb_q.size()) ? wb_q[k] : -1;
            chk($sformatf("tput_wb%0d", k), got, exp_wb[k]);
        end

        // Reset asserted in cycle 2 of EXEC, released in cycle 4
        do_reset();
        @(negedge clk_s);
        valid_s = 1'b1; a_s = 32'h1; b_s = 32'h2; id_s = 3'd4;
        @(negedge clk_s);
        idle_inputs();
        @(negedge clk_s);
        rst_n_s = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk_s);
        @(negedge clk_s);
        rst_n_s = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_s);
            #1;
            chk($sformatf("post_rst%0d_wbv", c), {31'd0, wbv_s}, 32'd0);
            chk($sformatf("post_rst%0d_busy", c), {31'd0, busy_s}, 32'd0);
            chk($sformatf("post_rst%0d_ready", c), {31'd0, ready_s}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/valu_ctrl.md
VALU_CTRL -- requirements
Module: valu_ctrl

Interface
REQ-001 Parameter TRANS_ID_BITS, default 3: width of scoreboard transaction ID.
REQ-002 Parameter LATENCY, default 2: VALU compute cycles; legal range 1..15.
REQ-003 Parameter STARVE_MAX, default 4: count of blocked writeback cycles before starve_o asserts; legal range 1..15.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 flush_i  in  1  pipeline flush; drops any in-flight operation.
REQ-007 valu_valid_i  in  1  issue request for a VALU operation.
REQ-008 valu_ready_o  out  1  controller can accept an operation.
REQ-009 trans_id_i  in  TRANS_ID_BITS  scoreboard ID of the issued operation.
REQ-010 operand_a_i, operand_b_i  in  32 each  source operands.
REQ-011 valu_op_a_o, valu_op_b_o  out  32 each  operands driven to the VALU datapath.
REQ-012 valu_result_i  in  32  VALU datapath result.
REQ-013 wb_busy_i  in  1  shared FLU writeback port claimed by ALU/branch/CSR/mult this cycle.
REQ-014 wb_valid_o  out  1  VALU result is on the FLU writeback port this cycle.
REQ-015 wb_trans_id_o  out  TRANS_ID_BITS  ID of the written-back operation.
REQ-016 wb_result_o  out  32  written-back result.
REQ-017 busy_o  out  1  state other than IDLE.
REQ-018 starve_o  out  1  requests the issue stage to hold fixed-latency issue.

Function
REQ-019 FSM states SHALL be IDLE, EXEC, WB.
REQ-020 IDLE: valu_ready_o=1; valu_valid_i=1 and flush_i=0 SHALL latch operands and trans_id, load cnt=LATENCY-1, and move to EXEC.
REQ-021 valu_op_a_o/valu_op_b_o SHALL carry the latched operands in EXEC and 0 in every other state (data silencing).
REQ-022 EXEC: cnt SHALL decrement each cycle; in the cycle with cnt=0, valu_result_i SHALL be captured into the result register and the FSM SHALL move to WB.
REQ-023 With the op accepted in cycle 0, EXEC SHALL occupy cycles 1..LATENCY and WB SHALL begin in cycle LATENCY+1.
REQ-024 WB: wb_valid_o SHALL equal !wb_busy_i; when wb_valid_o=1, the FSM SHALL return to IDLE at the next edge.
REQ-025 wb_trans_id_o and wb_result_o SHALL hold the latched values throughout WB, and SHALL be 0 outside WB.
REQ-026 In WB, a 4-bit wait counter SHALL increment each cycle in which wb_busy_i=1, saturating at 15, and SHALL clear on leaving WB.
REQ-027 starve_o SHALL be 1 while in WB with wait counter >= STARVE_MAX, and 0 otherwise.
REQ-028 flush_i=1 in any state SHALL force IDLE at the next edge, suppress wb_valid_o in that cycle, and block acceptance in that cycle.
REQ-029 valu_valid_i SHALL be ignored whenever valu_ready_o=0; the controller never queues a request.

Reset
REQ-030 During reset, the following SHALL hold: state=IDLE; cnt, wait counter, and latched operands/ID/result = 0; valu_ready_o=1; wb_valid_o, busy_o, starve_o = 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no writeback after release.

Configuration
REQ-032 VALU_CTRL_B2B_EN defined: valu_ready_o SHALL also be 1 in a WB cycle with wb_valid_o=1 and flush_i=0. An op accepted in that cycle SHALL enter EXEC directly, giving back-to-back throughput of one op per LATENCY+1 cycles.
REQ-033 VALU_CTRL_B2B_EN undefined: valu_ready_o SHALL be 1 only in IDLE, giving throughput of one op per LATENCY+2 cycles.

Verification
REQ-034 LATENCY=2; issue a=0x11, b=0x22, id=3 in cycle 0; wb_busy_i=0; VALU returns 0x33 -> wb_valid_o=1 in cycle 3 with id=3, result 0x33; IDLE in cycle 4.
REQ-035 Same op with wb_busy_i=1 during cycles 3-8 -> no wb_valid_o through cycle 8; starve_o=1 from cycle 7; wb_valid_o=1 in cycle 9; starve_o=0 in cycle 10.
REQ-036 flush_i=1 in cycle 2 during EXEC -> IDLE in cycle 3; wb_valid_o never asserts; valu_ready_o=1 in cycle 3.
REQ-037 valu_valid_i held high in cycles 1-3 after acceptance in cycle 0 -> no second accept before IDLE/WB eligibility; exactly one writeback per accepted op.
REQ-038 With VALU_CTRL_B2B_EN, continuous valid and wb_busy_i=0 -> accepts in cycles 0, 3, 6; writebacks in cycles 3, 6, 9. Without it -> accepts in cycles 0, 4, 8.
REQ-039 Reset asserted in cycle 2 of EXEC and released in cycle 4 -> all outputs at reset values and no writeback thereafter.
